mux_rud: RTL and testbench
==========================

Name: mux_rud

Overview:
- Write-back data selector for the register file (RU) of the single-cycle RISC-V CPU.
- Chooses among three sources:
  - ALU result (Calures)
  - data-memory read data (Bdatard)
  - PC+4 / next-instruction address (Aoutpc)
- Selection is driven by the 2-bit control MUXopRUW.
- The selected word is produced combinationally on outMuxdm. A registered copy plus status flags are provided for pipelining and debug.

Parameters:
- WIDTH, 32, data width of all data inputs and outputs.

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising clk edge.
- Aoutpc  input  WIDTH  next-PC value (PC+4), for JAL/JALR link.
- Bdatard  input  WIDTH  data-memory read data (loads).
- Calures  input  WIDTH  ALU result.
- MUXopRUW  input  2  source select: 00 = ALU, 01 = data memory, 10 = next PC, 11 = illegal.
- outMuxdm  output  WIDTH  combinational selected write-back data.
- outMuxdm_q  output  WIDTH  outMuxdm registered one cycle.
- sel_q  output  2  MUXopRUW registered one cycle.
- illegal_sel  output  1  sticky flag, set after any clock edge that samples MUXopRUW = 11.
- out_changed  output  1  one-cycle pulse: the registered output differs from its previous registered value.

Behaviour:
Combinational path (no clock or reset dependency):
- MUXopRUW = 00: outMuxdm = Calures.
- MUXopRUW = 01: outMuxdm = Bdatard.
- MUXopRUW = 10: outMuxdm = Aoutpc.
- MUXopRUW = 11: outMuxdm = all zeros.
- outMuxdm follows any input change within the same delta/cycle. It is valid immediately after inputs settle, with no clock required.
- Unselected inputs have no effect on outMuxdm.
- X/Z on MUXopRUW: the output takes the default (zero) branch. The implementation uses a full case with a default.

Registered path, on rising clk edge:
- rst_n = 0 clears everything: outMuxdm_q = 0, sel_q = 00, illegal_sel = 0, out_changed = 0.
  - Reset overrides all other updates in the same edge.
  - Reset mid-operation clears the sticky flag.
- rst_n = 1:
  - outMuxdm_q <= outMuxdm.
  - sel_q <= MUXopRUW.
  - illegal_sel <= illegal_sel | (MUXopRUW == 11). Once set, it stays set until reset.
  - out_changed <= (outMuxdm != outMuxdm_q). This compares the newly sampled value against the currently held registered value.

Timing:
- Latency: 0 cycles for outMuxdm, 1 cycle for outMuxdm_q and sel_q.
- Throughput: one selection per cycle.
- No handshake; no state machine beyond the sticky flag.
- First edge after reset release: out_changed = 1 iff the sampled outMuxdm is non-zero.

Test Plan:
- All inputs 0, MUXopRUW = 00; then Calures = AAAA5555 -> outMuxdm = AAAA5555 combinationally. After one clk: outMuxdm_q = AAAA5555, out_changed = 1.
- Bdatard = 12345678, MUXopRUW = 01 -> outMuxdm = 12345678. Next edge: sel_q = 01, outMuxdm_q = 12345678.
- Aoutpc = 87654321, MUXopRUW = 10 -> outMuxdm = 87654321. Next edge: outMuxdm_q = 87654321.
- Aoutpc = FFFFFFFF, Bdatard = 00000000, Calures = 55555555; sweep MUXopRUW 00/01/10 -> outMuxdm = 55555555 / 00000000 / FFFFFFFF. Changing the unselected inputs never alters the output.
- MUXopRUW = 11 for one cycle, then 00 -> outMuxdm = 0 while 11 is applied. illegal_sel = 1 after that edge and stays 1.
  - Then assert rst_n = 0 for one edge: all registered outputs = 0, illegal_sel = 0.
- Hold the inputs constant for 3 edges after a change -> out_changed is a single one-cycle pulse, then 0.

Source files
------------

// File: rtl/mux_rud.sv
// rtl/mux_rud.sv - register-file write-back source selector with registered copy and status flags
module mux_rud #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] Aoutpc,
  input  logic [WIDTH-1:0] Bdatard,
  input  logic [WIDTH-1:0] Calures,
  input  logic [1:0]       MUXopRUW,
  output logic [WIDTH-1:0] outMuxdm,
  output logic [WIDTH-1:0] outMuxdm_q,
  output logic [1:0]       sel_q,
  output logic             illegal_sel,
  output logic             out_changed
);

  // Source select; the illegal code and any unknown select fall to zero.
  always_comb begin
    outMuxdm = '0;
    case (MUXopRUW)
      2'b00:   outMuxdm = Calures;
      2'b01:   outMuxdm = Bdatard;
      2'b10:   outMuxdm = Aoutpc;
      default: outMuxdm = '0;
    endcase
  end

  // Registered copy, select history, sticky illegal flag and change pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outMuxdm_q  <= '0;
      sel_q       <= 2'b00;
      illegal_sel <= 1'b0;
      out_changed <= 1'b0;
    end else begin
      outMuxdm_q  <= outMuxdm;
      sel_q       <= MUXopRUW;
      illegal_sel <= illegal_sel | (MUXopRUW == 2'b11);
      out_changed <= (outMuxdm != outMuxdm_q);
    end
  end

endmodule

// File: tb/tb_mux_rud.sv
// tb/tb_mux_rud.sv - randomized self-checking bench for mux_rud against a behavioural model
module tb_mux_rud;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] Aoutpc;
  logic [WIDTH-1:0] Bdatard;
  logic [WIDTH-1:0] Calures;
  logic [1:0]       MUXopRUW;
  logic [WIDTH-1:0] outMuxdm;
  logic [WIDTH-1:0] outMuxdm_q;
  logic [1:0]       sel_q;
  logic             illegal_sel;
  logic             out_changed;

  int checks = 0;
  int errors = 0;

  // model state: what the registered outputs should hold after the last edge
  logic [WIDTH-1:0] m_q;
  logic [1:0]       m_sel;
  logic             m_ill;
  logic             m_chg;

  mux_rud #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .Aoutpc(Aoutpc),
    .Bdatard(Bdatard),
    .Calures(Calures),
    .MUXopRUW(MUXopRUW),
    .outMuxdm(outMuxdm),
    .outMuxdm_q(outMuxdm_q),
    .sel_q(sel_q),
    .illegal_sel(illegal_sel),
    .out_changed(out_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference selection: sources listed in select-code order, code 3 yields zero
  function automatic logic [WIDTH-1:0] pick(input logic [1:0] s, input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] srcs [3];
    srcs[0] = c;
    srcs[1] = b;
    srcs[2] = a;
    if (s < 2'd3) return srcs[s];
    return '0;
  endfunction

  // drive one cycle of stimulus, check the combinational output, clock, check registers
  task automatic cycle(input logic r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] c, input logic [1:0] s);
    logic [WIDTH-1:0] exp_comb;
    rst_n = r; Aoutpc = a; Bdatard = b; Calures = c; MUXopRUW = s;
    #1;
    exp_comb = pick(s, a, b, c);
    chk("comb", outMuxdm, exp_comb);
    @(posedge clk);
    if (!r) begin
      m_q = '0; m_sel = 2'b00; m_ill = 1'b0; m_chg = 1'b0;
    end else begin
      m_chg = (exp_comb != m_q);
      m_q   = exp_comb;
      m_sel = s;
      m_ill = m_ill || (s == 2'b11);
    end
    #1;
    chk("out_q", outMuxdm_q, m_q);
    chk("sel_q", {30'd0, sel_q}, {30'd0, m_sel});
    chk("illegal", {31'd0, illegal_sel}, {31'd0, m_ill});
    chk("changed", {31'd0, out_changed}, {31'd0, m_chg});
  endtask

  initial begin
    m_q = '0; m_sel = '0; m_ill = 1'b0; m_chg = 1'b0;
    rst_n = 1'b0; Aoutpc = '0; Bdatard = '0; Calures = '0; MUXopRUW = 2'b00;
    @(negedge clk);

    // reset state
    cycle(1'b0, '0, '0, '0, 2'b00);
    cycle(1'b0, '0, '0, '0, 2'b00);
    // first edge after release with zero output: no change pulse
    cycle(1'b1, '0, '0, '0, 2'b00);
    // ALU, memory, next-PC sources
    cycle(1'b1, '0, '0, 32'hAAAA5555, 2'b00);
    cycle(1'b1, '0, 32'h12345678, 32'hAAAA5555, 2'b01);
    cycle(1'b1, 32'h87654321, 32'h12345678, 32'hAAAA5555, 2'b10);
    // sweep with fixed patterns, then disturb unselected inputs
    cycle(1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h55555555, 2'b00);
    cycle(1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h55555555, 2'b01);
    cycle(1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h55555555, 2'b10);
    cycle(1'b1, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h01234567, 2'b10);
    cycle(1'b1, 32'h0BADF00D, 32'hDEADBEEF, 32'h01234567, 2'b00);
    // illegal select, sticky flag, then reset mid-operation
    cycle(1'b1, 32'h0BADF00D, 32'hDEADBEEF, 32'h01234567, 2'b11);
    cycle(1'b1, 32'h0BADF00D, 32'hDEADBEEF, 32'h01234567, 2'b00);
    cycle(1'b1, 32'h0BADF00D, 32'hDEADBEEF, 32'h01234567, 2'b00);
    cycle(1'b0, 32'h0BADF00D, 32'hDEADBEEF, 32'h01234567, 2'b11);
    // change then hold for three edges: single pulse
    cycle(1'b1, '0, '0, 32'h00C0FFEE, 2'b00);
    cycle(1'b1, '0, '0, 32'h00C0FFEE, 2'b00);
    cycle(1'b1, '0, '0, 32'h00C0FFEE, 2'b00);
    cycle(1'b1, '0, '0, 32'h00C0FFEE, 2'b00);

    // randomized traffic with occasional resets and held stretches
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic [1:0] s;
      r = ($urandom_range(0, 24) != 0);
      s = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0)
        cycle(r, Aoutpc, Bdatard, Calures, MUXopRUW);
      else
        cycle(r, $urandom, $urandom, $urandom, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
